// File: rtl/dwt_analysis.sv
// Single-level DWT analysis stage: 12-tap low/high-pass filter pair, decimated by 2, one time-shared MAC per branch.
// Define DWT_SAT_EN to saturate the output coefficients instead of wrapping them to pOUT_W bits.
module dwt_analysis #(
    parameter int pIDAT_W = 18,
    parameter int pCOEF_W = 18,
    parameter int pACC_W  = 40,
    parameter int pSHIFT  = 0,
    parameter int pOUT_W  = 40
) (
    input  logic                      iclk,
    input  logic                      irst,
    input  logic                      iclk_ena,
    input  logic                      iena,
    input  logic signed [pIDAT_W-1:0] idat,
    output logic signed [pOUT_W-1:0]  odat_l,
    output logic signed [pOUT_W-1:0]  odat_h,
    output logic                      oena,
    output logic                      oerr
);

    localparam int NTAP   = 12;
    localparam int PROD_W = pIDAT_W + pCOEF_W;
    localparam int WIDE_W = (pOUT_W > pACC_W) ? pOUT_W : pACC_W;

    localparam logic signed [pCOEF_W-1:0] C_L [NTAP] = '{
        -18'sd71, 18'sd313, 18'sd36, -18'sd2070, 18'sd1803, 18'sd6389,
        -18'sd8505, -18'sd14829, 18'sd20660, 18'sd49226, 18'sd32415, 18'sd7309};
    localparam logic signed [pCOEF_W-1:0] C_H [NTAP] = '{
        -18'sd7310, 18'sd32415, -18'sd49227, 18'sd20660, 18'sd14828, -18'sd8505,
        -18'sd6390, 18'sd1803, 18'sd2069, 18'sd36, -18'sd314, -18'sd71};

`ifdef DWT_SAT_EN
    localparam logic signed [WIDE_W-1:0] SAT_MAX =
        signed'({{(WIDE_W-pOUT_W+1){1'b0}}, {(pOUT_W-1){1'b1}}});
    localparam logic signed [WIDE_W-1:0] SAT_MIN =
        signed'({{(WIDE_W-pOUT_W+1){1'b1}}, {(pOUT_W-1){1'b0}}});
`endif

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  k_q, k_d;
    logic                        phase_q, phase_d;
    logic signed [pIDAT_W-1:0]   d_q [NTAP];
    logic signed [pIDAT_W-1:0]   d_d [NTAP];
    logic signed [pIDAT_W-1:0]   snap_q [NTAP];
    logic signed [pIDAT_W-1:0]   snap_d [NTAP];
    logic signed [pACC_W-1:0]    acc_l_q, acc_l_d, acc_h_q, acc_h_d;
    logic signed [pOUT_W-1:0]    odat_l_q, odat_l_d, odat_h_q, odat_h_d;
    logic                        oena_q, oena_d;
    logic                        oerr_q, oerr_d;

    logic                        accept, launch;
    logic signed [PROD_W-1:0]    prod_l, prod_h;
    logic signed [pACC_W-1:0]    shift_l, shift_h;
    logic signed [WIDE_W-1:0]    wide_l, wide_h;

    // Final width reduction: clamp or two's-complement wrap depending on build.
    function automatic logic signed [pOUT_W-1:0] reduce(input logic signed [WIDE_W-1:0] v);
`ifdef DWT_SAT_EN
        if (v > SAT_MAX)
            return SAT_MAX[pOUT_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[pOUT_W-1:0];
        else
            return v[pOUT_W-1:0];
`else
        return v[pOUT_W-1:0];
`endif
    endfunction

    assign accept  = iclk_ena & iena;
    assign launch  = accept & phase_q;
    assign prod_l  = PROD_W'(C_L[k_q]) * PROD_W'(snap_q[k_q]);
    assign prod_h  = PROD_W'(C_H[k_q]) * PROD_W'(snap_q[k_q]);
    assign shift_l = acc_l_q >>> pSHIFT;
    assign shift_h = acc_h_q >>> pSHIFT;
    assign wide_l  = WIDE_W'(shift_l);
    assign wide_h  = WIDE_W'(shift_h);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        phase_d  = phase_q;
        d_d      = d_q;
        snap_d   = snap_q;
        acc_l_d  = acc_l_q;
        acc_h_d  = acc_h_q;
        odat_l_d = odat_l_q;
        odat_h_d = odat_h_q;
        oena_d   = 1'b0;
        oerr_d   = oerr_q;

        // The delay line advances regardless of what the MAC is doing.
        if (accept) begin
            for (int i = NTAP - 1; i > 0; i--)
                d_d[i] = d_q[i-1];
            d_d[0]  = idat;
            phase_d = ~phase_q;
        end

        if (launch && (state_q != S_IDLE))
            oerr_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    snap_d  = d_d;
                    state_d = S_MAC;
                    k_d     = 4'd0;
                    acc_l_d = '0;
                    acc_h_d = '0;
                end
            end
            S_MAC: begin
                acc_l_d = acc_l_q + pACC_W'(prod_l);
                acc_h_d = acc_h_q + pACC_W'(prod_h);
                if (k_q == 4'(NTAP - 1))
                    state_d = S_DONE;
                else
                    k_d = k_q + 4'd1;
            end
            S_DONE: begin
                odat_l_d = reduce(wide_l);
                odat_h_d = reduce(wide_h);
                oena_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            phase_q  <= 1'b0;
            d_q      <= '{default: '0};
            snap_q   <= '{default: '0};
            acc_l_q  <= '0;
            acc_h_q  <= '0;
            odat_l_q <= '0;
            odat_h_q <= '0;
            oena_q   <= 1'b0;
            oerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            phase_q  <= phase_d;
            d_q      <= d_d;
            snap_q   <= snap_d;
            acc_l_q  <= acc_l_d;
            acc_h_q  <= acc_h_d;
            odat_l_q <= odat_l_d;
            odat_h_q <= odat_h_d;
            oena_q   <= oena_d;
            oerr_q   <= oerr_d;
        end
    end

    assign odat_l = odat_l_q;
    assign odat_h = odat_h_q;
    assign oena   = oena_q;
    assign oerr   = oerr_q;

endmodule

// File: tb/tb_dwt_analysis.sv
// Directed bench for dwt_analysis: vector table (impulses, DC) plus hand sequences for
// iena gaps, overrun, reset during MAC, and a narrow-output instance for saturation/wrap.
module tb_dwt_analysis;

    logic               iclk = 1'b0;
    logic               irst = 1'b0;
    logic               iclk_ena = 1'b0;
    logic               iena = 1'b0;
    logic signed [17:0] idat = '0;
    logic signed [17:0] idat_sat = 18'sd131071;
    logic signed [39:0] odat_l, odat_h;
    logic signed [23:0] sat_l, sat_h;
    logic               oena, oerr, sat_oena, sat_oerr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [17:0] din;
        bit                 chk;
        longint             exp_l;
        longint             exp_h;
    } vec_t;

    vec_t vecs [42];

    dwt_analysis dut (
        .iclk(iclk), .irst(irst), .iclk_ena(iclk_ena), .iena(iena), .idat(idat),
        .odat_l(odat_l), .odat_h(odat_h), .oena(oena), .oerr(oerr)
    );

    dwt_analysis #(.pOUT_W(24)) dut_sat (
        .iclk(iclk), .irst(irst), .iclk_ena(iclk_ena), .iena(iena), .idat(idat_sat),
        .odat_l(sat_l), .odat_h(sat_h), .oena(sat_oena), .oerr(sat_oerr)
    );

    always #5 iclk = ~iclk;

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic doReset();
        @(negedge iclk);
        irst     = 1'b1;
        iclk_ena = 1'b0;
        iena     = 1'b0;
        repeat (2) @(negedge iclk);
        irst = 1'b0;
    endtask

    // One strobe, then watch 20 cycles for oena: count, latency and captured data.
    task automatic applyStimulus(input logic signed [17:0] din, input bit ena, input bit launch,
                                 input bit chk, input longint el, input longint eh, input string tag);
        int     n_oena;
        int     lat;
        longint cap_l;
        longint cap_h;
        n_oena = 0;
        lat    = -1;
        cap_l  = 0;
        cap_h  = 0;
        @(negedge iclk);
        idat     = din;
        iena     = ena;
        iclk_ena = 1'b1;
        @(negedge iclk);
        iclk_ena = 1'b0;
        iena     = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge iclk);
            #1;
            if (oena) begin
                n_oena++;
                if (lat < 0) begin
                    lat   = c;
                    cap_l = odat_l;
                    cap_h = odat_h;
                end
            end
        end
        if (launch) begin
            checkOutput({tag, "_oena_cnt"}, n_oena, 1);
            checkOutput({tag, "_latency"}, lat, 13);
            if (chk) begin
                checkOutput({tag, "_L"}, cap_l, el);
                checkOutput({tag, "_H"}, cap_h, eh);
            end
        end else begin
            checkOutput({tag, "_oena_cnt"}, n_oena, 0);
        end
    endtask

    initial begin
        int     first_oena;
        int     n_oena;
        longint cap_l, cap_h;
        logic   oerr_11, oerr_12;
        longint exp_sat_l;

        foreach (vecs[i]) begin
            vecs[i].din   = '0;
            vecs[i].chk   = 1'b0;
            vecs[i].exp_l = 0;
            vecs[i].exp_h = 0;
        end
        // Negative full-scale impulse
        vecs[0].din = -18'sd131072;
        vecs[1].chk = 1'b1; vecs[1].exp_l = -41025536; vecs[1].exp_h = -64'sd4248698880;
        // Unit impulse: odd taps appear one per output
        vecs[14].din = 18'sd1;
        vecs[15].chk = 1'b1; vecs[15].exp_l = 313;    vecs[15].exp_h = 32415;
        vecs[17].chk = 1'b1; vecs[17].exp_l = -2070;  vecs[17].exp_h = 20660;
        vecs[19].chk = 1'b1; vecs[19].exp_l = 6389;   vecs[19].exp_h = -8505;
        vecs[21].chk = 1'b1; vecs[21].exp_l = -14829; vecs[21].exp_h = 1803;
        vecs[23].chk = 1'b1; vecs[23].exp_l = 49226;  vecs[23].exp_h = 36;
        vecs[25].chk = 1'b1; vecs[25].exp_l = 7309;   vecs[25].exp_h = -71;
        vecs[27].chk = 1'b1; vecs[27].exp_l = 0;      vecs[27].exp_h = 0;
        // DC step of 1000: partial windows then full window
        for (int i = 28; i < 42; i++) vecs[i].din = 18'sd1000;
        vecs[29].chk = 1'b1; vecs[29].exp_l = 242000;   vecs[29].exp_h = 25105000;
        vecs[31].chk = 1'b1; vecs[31].exp_l = -1792000; vecs[31].exp_h = -3462000;
        vecs[39].chk = 1'b1; vecs[39].exp_l = 92676000; vecs[39].exp_h = -6000;
        vecs[41].chk = 1'b1; vecs[41].exp_l = 92676000; vecs[41].exp_h = -6000;

        doReset();
        #1;
        checkOutput("rst_odat_l", odat_l, 0);
        checkOutput("rst_odat_h", odat_h, 0);
        checkOutput("rst_oena", oena, 0);
        checkOutput("rst_oerr", oerr, 0);

        foreach (vecs[i])
            applyStimulus(vecs[i].din, 1'b1, (i % 2) == 1, vecs[i].chk,
                          vecs[i].exp_l, vecs[i].exp_h, $sformatf("vec%0d", i));
        checkOutput("no_overrun_oerr", oerr, 0);

`ifdef DWT_SAT_EN
        exp_sat_l = 8388607;
`else
        exp_sat_l = 431612;
`endif
        checkOutput("sat_L", sat_l, exp_sat_l);
        checkOutput("sat_H", sat_h, -786426);

        // Strobes with iena low must not shift or count toward decimation
        doReset();
        applyStimulus(18'sd5,   1'b1, 1'b0, 1'b0, 0, 0, "gap_s0");
        applyStimulus(18'sd999, 1'b0, 1'b0, 1'b0, 0, 0, "gap_skip");
        applyStimulus(18'sd7,   1'b1, 1'b1, 1'b1, 1068, 110905, "gap_s1");

        // Overrun: strobe every 4 cycles, launches every 8
        doReset();
        first_oena = -1;
        n_oena     = 0;
        cap_l      = 0;
        cap_h      = 0;
        oerr_11    = 1'b0;
        oerr_12    = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge iclk);
            iclk_ena = ((cyc % 4) == 0) && (cyc < 16);
            iena     = 1'b1;
            idat     = (cyc == 0) ? 18'sd1 : 18'sd0;
            @(posedge iclk);
            #1;
            if (oena) begin
                n_oena++;
                if (first_oena < 0) begin
                    first_oena = cyc;
                    cap_l      = odat_l;
                    cap_h      = odat_h;
                end
            end
            if (cyc == 11) oerr_11 = oerr;
            if (cyc == 12) oerr_12 = oerr;
        end
        iclk_ena = 1'b0;
        iena     = 1'b0;
        checkOutput("ovr_oerr_before", oerr_11, 0);
        checkOutput("ovr_oerr_set", oerr_12, 1);
        checkOutput("ovr_oerr_sticky", oerr, 1);
        checkOutput("ovr_oena_cnt", n_oena, 1);
        checkOutput("ovr_oena_cycle", first_oena, 17);
        checkOutput("ovr_L", cap_l, 313);
        checkOutput("ovr_H", cap_h, 32415);
        doReset();
        #1;
        checkOutput("ovr_oerr_cleared", oerr, 0);

        // Reset five cycles into a computation
        applyStimulus(18'sd100, 1'b1, 1'b0, 1'b0, 0, 0, "rmac_s0");
        @(negedge iclk);
        idat     = 18'sd200;
        iena     = 1'b1;
        iclk_ena = 1'b1;
        @(posedge iclk);
        @(negedge iclk);
        iclk_ena = 1'b0;
        iena     = 1'b0;
        repeat (4) @(posedge iclk);
        @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk);
        irst   = 1'b0;
        n_oena = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge iclk);
            #1;
            if (oena) n_oena++;
        end
        checkOutput("rmac_oena_cnt", n_oena, 0);
        checkOutput("rmac_odat_l", odat_l, 0);
        checkOutput("rmac_odat_h", odat_h, 0);
        applyStimulus(18'sd3,  1'b1, 1'b0, 1'b0, 0, 0, "rmac_n0");
        applyStimulus(-18'sd4, 1'b1, 1'b1, 1'b1, 1223, 126485, "rmac_n1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
